// File: rtl/vec_driver.sv
// vec_driver: drives each written vector onto the DUT pins, samples the loopback after a
// settle time and keeps pass/fail plus a saturating error count. Macro VEC_DRV_SYNC2_EN adds an in_dut synchronizer.
module vec_driver #(
   parameter int SETTLE_CYC = 4,
   parameter int VEC_W      = 6
) (
   input  logic             in_clk,
   input  logic             in_rst_n,
   input  logic [VEC_W-1:0] in_vec,
   input  logic             in_vec_vld,
   input  logic [VEC_W-1:0] in_dut,
   input  logic             in_clr_err,
   output logic [VEC_W-1:0] out_dut,
   output logic             out_busy,
   output logic             out_done,
   output logic             out_pass,
   output logic [7:0]       out_err_cnt,
   output logic             out_ovf
);

`ifdef VEC_DRV_SYNC2_EN
   // two extra settle cycles cover the synchronizer so pins are still sampled SETTLE_CYC after drive
   localparam int SETTLE_TOT = SETTLE_CYC + 2;
`else
   localparam int SETTLE_TOT = SETTLE_CYC;
`endif
   localparam logic [8:0] CNT_LAST = 9'(SETTLE_TOT - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;

   state_t           state_q, state_d;
   logic [8:0]       cnt_q;
   logic [VEC_W-1:0] vec_q;
   logic [VEC_W-1:0] dut_s;
   logic             accept, drop, match;

`ifdef VEC_DRV_SYNC2_EN
   logic [VEC_W-1:0] sync_q1, sync_q2;

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= in_dut;
         sync_q2 <= sync_q1;
      end
   end
   assign dut_s = sync_q2;
`else
   assign dut_s = in_dut;
`endif

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_vec_vld) state_d = SETTLE;
         SETTLE:  if (cnt_q == CNT_LAST) state_d = CHECK;
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_busy = (state_q != IDLE);
      accept   = (state_q == IDLE) && in_vec_vld;
      drop     = (state_q != IDLE) && in_vec_vld;
      match    = (dut_s == vec_q);
   end

   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         cnt_q       <= '0;
         vec_q       <= '0;
         out_dut     <= '0;
         out_done    <= 1'b0;
         out_pass    <= 1'b0;
         out_err_cnt <= '0;
         out_ovf     <= 1'b0;
      end else begin
         out_done <= (state_q == CHECK);
         if (accept) begin
            vec_q   <= in_vec;
            out_dut <= in_vec;
            cnt_q   <= '0;
         end else if (state_q == SETTLE) begin
            cnt_q <= cnt_q + 9'd1;
         end
         if (state_q == CHECK) out_pass <= match;
         // host clear wins over a same-edge failure or overflow
         if (in_clr_err) begin
            out_err_cnt <= '0;
            out_ovf     <= 1'b0;
         end else begin
            if ((state_q == CHECK) && !match && (out_err_cnt != 8'hFF))
               out_err_cnt <= out_err_cnt + 8'd1;
            if (drop) out_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vec_driver.sv
// Scoreboard bench for vec_driver: stimulus pushes expected compare results, a negedge
// monitor pops and checks them on every out_done pulse.
module tb_vec_driver;
   localparam int SETTLE_CYC = 4;
`ifdef VEC_DRV_SYNC2_EN
   localparam int LAT = SETTLE_CYC + 3;
`else
   localparam int LAT = SETTLE_CYC + 1;
`endif

   typedef struct {
      logic       pass;
      logic [7:0] err;
      int         cyc;
   } exp_t;

   logic       in_clk = 1'b0;
   logic       in_rst_n = 1'b0;
   logic [5:0] in_vec = '0;
   logic       in_vec_vld = 1'b0;
   logic [5:0] in_dut;
   logic       in_clr_err = 1'b0;
   logic [5:0] out_dut;
   logic       out_busy, out_done, out_pass, out_ovf;
   logic [7:0] out_err_cnt;

   logic       loop_en = 1'b1;
   logic [5:0] force_val = '0;
   exp_t       sb[$];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   int         model_err = 0;

   vec_driver #(.SETTLE_CYC(SETTLE_CYC)) dut (
      .in_clk(in_clk), .in_rst_n(in_rst_n), .in_vec(in_vec), .in_vec_vld(in_vec_vld),
      .in_dut(in_dut), .in_clr_err(in_clr_err), .out_dut(out_dut), .out_busy(out_busy),
      .out_done(out_done), .out_pass(out_pass), .out_err_cnt(out_err_cnt), .out_ovf(out_ovf)
   );

   // loopback fixture, or pins forced to a fixed value
   assign in_dut = loop_en ? out_dut : force_val;

   always #5 in_clk = ~in_clk;
   always @(posedge in_clk) cyc <= cyc + 1;

   function automatic void chk(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endfunction

   function automatic void push_exp(logic [5:0] v, bit clr_at_chk, int done_cyc);
      exp_t e;
      e.pass = loop_en ? 1'b1 : (v == force_val);
      if (clr_at_chk)                      model_err = 0;
      else if (!e.pass && model_err < 255) model_err++;
      e.err = 8'(model_err);
      e.cyc = done_cyc;
      sb.push_back(e);
   endfunction

   // returns #1 after the accepting edge
   task automatic issue(input logic [5:0] v, input bit clr_at_chk);
      @(posedge in_clk); #1;
      in_vec = v;
      in_vec_vld = 1'b1;
      push_exp(v, clr_at_chk, cyc + 1 + LAT);
      @(posedge in_clk); #1;
      in_vec_vld = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 4 * LAT + 20) begin
         @(negedge in_clk);
         t++;
      end
      chk("drain", sb.size(), 0);
   endtask

   always @(negedge in_clk) begin
      exp_t e;
      if (in_rst_n && out_done) begin
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("pass", int'(out_pass), int'(e.pass));
            chk("err_cnt", int'(out_err_cnt), int'(e.err));
         end
      end
   end

   initial begin
      int t;
      int nd;
      repeat (3) @(posedge in_clk);
      @(negedge in_clk);
      chk("rst_dut", int'(out_dut), 0);
      chk("rst_busy", int'(out_busy), 0);
      chk("rst_done", int'(out_done), 0);
      chk("rst_pass", int'(out_pass), 0);
      chk("rst_err", int'(out_err_cnt), 0);
      chk("rst_ovf", int'(out_ovf), 0);
      @(posedge in_clk); #1;
      in_rst_n = 1'b1;

      // loopback pass
      issue(6'h2A, 1'b0);
      @(negedge in_clk);
      chk("t1_dut", int'(out_dut), 'h2A);
      chk("t1_busy", int'(out_busy), 1);
      drain();

      // pins stuck at 0: two failures, then a matching vector
      loop_en = 1'b0;
      force_val = 6'h00;
      issue(6'h01, 1'b0); drain();
      issue(6'h3F, 1'b0); drain();
      issue(6'h00, 1'b0); drain();
      chk("t2_err", int'(out_err_cnt), 2);

      // dropped vector during settle, then a vector on the done cycle
      loop_en = 1'b1;
      issue(6'h0A, 1'b0);
      in_vec = 6'h15;
      in_vec_vld = 1'b1;
      @(posedge in_clk); #1;
      in_vec_vld = 1'b0;
      @(negedge in_clk);
      chk("t3_ovf", int'(out_ovf), 1);
      chk("t3_dut_held", int'(out_dut), 'h0A);
      t = 0;
      while (!out_done && t < 4 * LAT) begin
         @(negedge in_clk);
         t++;
      end
      chk("t3_done_seen", int'(out_done), 1);
      in_vec = 6'h0C;
      in_vec_vld = 1'b1;
      push_exp(6'h0C, 1'b0, cyc + 1 + LAT);
      @(posedge in_clk); #1;
      in_vec_vld = 1'b0;
      @(negedge in_clk);
      chk("t3_dut_next", int'(out_dut), 'h0C);
      drain();
      @(posedge in_clk); #1;
      in_clr_err = 1'b1;
      model_err = 0;
      @(posedge in_clk); #1;
      in_clr_err = 1'b0;
      @(negedge in_clk);
      chk("t3_clr_ovf", int'(out_ovf), 0);
      chk("t3_clr_err", int'(out_err_cnt), 0);

      // saturation
      loop_en = 1'b0;
      for (int i = 0; i < 300; i++) begin
         issue(6'h01, 1'b0);
         drain();
      end
      chk("t4_sat", int'(out_err_cnt), 255);
      // clear coinciding with a failing compare and an overflow
      issue(6'h01, 1'b1);
      in_vec = 6'h03;
      in_vec_vld = 1'b1;
      @(posedge in_clk); #1;
      in_vec_vld = 1'b0;
      @(negedge in_clk);
      chk("t4_ovf_set", int'(out_ovf), 1);
      repeat (LAT - 2) @(posedge in_clk);
      #1 in_clr_err = 1'b1;
      @(posedge in_clk); #1;
      in_clr_err = 1'b0;
      @(negedge in_clk);
      chk("t4_clr_ovf", int'(out_ovf), 0);
      chk("t4_clr_err", int'(out_err_cnt), 0);
      drain();

      // reset while settling
      loop_en = 1'b1;
      issue(6'h2A, 1'b0);
      drain();
      issue(6'h1E, 1'b0);
      @(posedge in_clk); #1;
      in_rst_n = 1'b0;
      @(posedge in_clk); #1;
      in_rst_n = 1'b1;
      void'(sb.pop_back());
      model_err = 0;
      @(negedge in_clk);
      chk("t5_dut", int'(out_dut), 0);
      chk("t5_busy", int'(out_busy), 0);
      chk("t5_pass", int'(out_pass), 0);
      chk("t5_err", int'(out_err_cnt), 0);
      chk("t5_ovf", int'(out_ovf), 0);
      nd = 0;
      repeat (LAT + 3) begin
         @(negedge in_clk);
         if (out_done) nd++;
      end
      chk("t5_no_done", nd, 0);
      issue(6'h07, 1'b0);
      drain();

      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vec_driver.md
# vec_driver

Test-vector driver stage downstream of the 6-bit vector register in the FPGA tester. It takes each newly written vector (register output plus one-cycle write-ready pulse) and drives it onto the 6 DUT stimulus pins. After a programmable settle time it samples the 6 DUT response pins and compares them against the driven vector (loopback fixture). It reports pass/fail per vector and keeps a saturating error count for the host side.

## Interface
- SETTLE_CYC, 4, cycles between driving out_dut and sampling in_dut; legal range 1..255
- in_clk  in  1  sole clock, rising edge
- in_rst_n  in  1  synchronous, active-low reset
- in_vec  in  6  vector from the vector register (its out_mem)
- in_vec_vld  in  1  one-cycle pulse: new vector on in_vec (register's mem_wrt_rd)
- in_dut  in  6  DUT response pins (asynchronous to in_clk when sync is compiled in)
- in_clr_err  in  1  clears out_err_cnt and out_ovf
- out_dut  out  6  DUT stimulus pins
- out_busy  out  1  high while a vector is in flight
- out_done  out  1  one-cycle pulse: compare finished
- out_pass  out  1  result of last compare (1 = in_dut matched)
- out_err_cnt  out  8  number of failed compares, saturates at 255
- out_ovf  out  1  sticky: a vector arrived while busy and was dropped

## Operation
- Reset (in_rst_n low at an edge): state IDLE; out_dut=0, out_busy=0, out_done=0, out_pass=0, out_err_cnt=0, out_ovf=0, settle counter=0, latched vector=0. Reset mid-operation aborts the vector with no out_done pulse.
- FSM states: IDLE, SETTLE, CHECK.
- IDLE: at an edge with in_vec_vld=1: latch in_vec, out_dut<=in_vec, counter<=0, go SETTLE. Otherwise hold; out_dut keeps the last driven vector.
- SETTLE: counter increments each edge; at the edge where counter==SETTLE_TOT-1, go CHECK. SETTLE_TOT = SETTLE_CYC, or SETTLE_CYC+2 with sync (see Configuration). Counter is 9 bits wide.
- CHECK (one edge): match = (sampled in_dut == latched vector). out_pass<=match; if !match and out_err_cnt<255, out_err_cnt increments. out_done<=1. Go IDLE.
- out_busy is high in SETTLE and CHECK (registered, so it rises the cycle after the accepting edge).
- in_vec_vld in SETTLE or CHECK: the vector is dropped, out_ovf<=1, and the in-flight vector is unaffected.
- in_clr_err=1: out_err_cnt<=0 and out_ovf<=0. This takes priority over a same-edge increment or overflow set. out_pass is not cleared.
- out_done is high for exactly one cycle per accepted vector.

## Timing
- Vector accepted at edge E0. out_dut changes after E0. SETTLE occupies E1..E_SETTLE_TOT. CHECK samples at E_(SETTLE_TOT+1). out_done, out_pass and out_err_cnt are valid after that edge.
- Latency from vld edge to done: SETTLE_CYC+1 edges without sync, SETTLE_CYC+3 with sync. Default is 5 or 7.
- out_done falls at the next edge, which is in IDLE, so a vld at that same edge is accepted. Back-to-back throughput is 1 vector per SETTLE_TOT+2 cycles.
- No combinational path from any input to any output.

## Configuration
- VEC_DRV_SYNC2_EN defined: in_dut passes through a two-flop synchronizer (reset to 0) before compare, and SETTLE_TOT = SETTLE_CYC+2, so the compare sees the pins exactly SETTLE_CYC cycles after drive.
- Not defined: in_dut is compared directly (fixture must be synchronous to in_clk), and SETTLE_TOT = SETTLE_CYC.

## Test plan
- Reset then loopback (in_dut=out_dut), SETTLE_CYC=4, no sync: vld with in_vec=6'h2A -> out_dut=6'h2A next cycle; out_done after 5th edge; out_pass=1; out_err_cnt=0.
- Fixture in_dut forced 6'h00, vectors 6'h01, 6'h3F -> two done pulses, out_pass=0 each, out_err_cnt=2.
- vld at settle cycle 2 with 6'h15 during vector 6'h0A -> out_ovf=1, out_dut stays 6'h0A, one done only; vld on done cycle -> accepted.
- 300 failing vectors -> out_err_cnt=255 and holds; in_clr_err with a simultaneous fail -> out_err_cnt=0, out_ovf=0.
- in_rst_n low during SETTLE -> all outputs 0 next cycle, no out_done; new vld after release runs normally.
- VEC_DRV_SYNC2_EN defined, loopback 6'h33 -> done after 7 edges, out_pass=1.
